// File: rtl/logic_unit_seq_if.sv
// Operand/result handshake bundle for the sliced logic unit.
// master drives operands and consumes results; slave is the unit itself.
interface logic_unit_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: one SLICE-bit slice per cycle, LSB first, with a zero flag.
// Latency NSLICE cycles from accept to out_valid; DONE holds under out_ready=0 and accepts nothing.
module logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  logic_unit_seq_if.slave  bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_sl;
  logic             w_last;
  logic             w_sl_nz;

  assign w_last  = (r_cnt == CW'(NSLICE - 1));
  assign w_sl_nz = |w_sl;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)  w_next = S_BUSY;
      S_BUSY:  if (w_last)        w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.out_valid = (r_state == S_DONE);
    bus.result    = r_result;
    bus.zero      = r_zero;
  end

  // Constant-index mux keeps the slice select free of variable part-selects.
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int j = 0; j < NSLICE; j++) begin
      if (r_cnt == CW'(j)) begin
        w_a_sl = r_a[j*SLICE +: SLICE];
        w_b_sl = r_b[j*SLICE +: SLICE];
      end
    end
  end

  always_comb begin
    case (r_op)
      3'b000:  w_sl = w_a_sl & w_b_sl;
      3'b001:  w_sl = ~(w_a_sl & w_b_sl);
      3'b010:  w_sl = w_a_sl | w_b_sl;
      3'b011:  w_sl = ~(w_a_sl | w_b_sl);
      3'b100:  w_sl = w_a_sl ^ w_b_sl;
      3'b101:  w_sl = ~(w_a_sl ^ w_b_sl);
      3'b110:  w_sl = ~w_a_sl;
      default: w_sl = w_a_sl;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_acc    <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_op  <= bus.op;
            r_cnt <= '0;
            r_acc <= 1'b0;
          end
        end
        S_BUSY: begin
          for (int j = 0; j < NSLICE; j++) begin
            if (r_cnt == CW'(j)) r_result[j*SLICE +: SLICE] <= w_sl;
          end
          r_acc <= r_acc | w_sl_nz;
          if (w_last) r_zero <= ~(r_acc | w_sl_nz);
          else        r_cnt  <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: four parameterisations driven side by side against a whole-word model.
module tb_logic_unit_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  logic [63:0] d_a [4];
  logic [63:0] d_b [4];
  logic [2:0]  d_op[4];
  logic        d_iv[4];
  logic        d_or[4];

  logic [63:0] o_res[4];
  logic        o_zero[4];
  logic        o_ov[4];
  logic        o_ir[4];

  logic_unit_seq_if #(.WIDTH(32)) if0 ();
  logic_unit_seq_if #(.WIDTH(8))  if1 ();
  logic_unit_seq_if #(.WIDTH(16)) if2 ();
  logic_unit_seq_if #(.WIDTH(64)) if3 ();

  logic_unit_seq #(.WIDTH(32), .SLICE(8))  u0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
  logic_unit_seq #(.WIDTH(8),  .SLICE(8))  u1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  logic_unit_seq #(.WIDTH(16), .SLICE(1))  u2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));
  logic_unit_seq #(.WIDTH(64), .SLICE(16)) u3 (.clk(clk), .reset_n(reset_n), .bus(if3.slave));

  assign if0.a = d_a[0][31:0]; assign if0.b = d_b[0][31:0]; assign if0.op = d_op[0];
  assign if1.a = d_a[1][7:0];  assign if1.b = d_b[1][7:0];  assign if1.op = d_op[1];
  assign if2.a = d_a[2][15:0]; assign if2.b = d_b[2][15:0]; assign if2.op = d_op[2];
  assign if3.a = d_a[3];       assign if3.b = d_b[3];       assign if3.op = d_op[3];
  assign if0.in_valid = d_iv[0]; assign if0.out_ready = d_or[0];
  assign if1.in_valid = d_iv[1]; assign if1.out_ready = d_or[1];
  assign if2.in_valid = d_iv[2]; assign if2.out_ready = d_or[2];
  assign if3.in_valid = d_iv[3]; assign if3.out_ready = d_or[3];

  assign o_res[0] = 64'(if0.result); assign o_zero[0] = if0.zero;
  assign o_res[1] = 64'(if1.result); assign o_zero[1] = if1.zero;
  assign o_res[2] = 64'(if2.result); assign o_zero[2] = if2.zero;
  assign o_res[3] = if3.result;      assign o_zero[3] = if3.zero;
  assign o_ov[0] = if0.out_valid; assign o_ir[0] = if0.in_ready;
  assign o_ov[1] = if1.out_valid; assign o_ir[1] = if1.in_ready;
  assign o_ov[2] = if2.out_valid; assign o_ir[2] = if2.in_ready;
  assign o_ov[3] = if3.out_valid; assign o_ir[3] = if3.in_ready;

  function automatic int width_of(int u);
    case (u)
      0: return 32;
      1: return 8;
      2: return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int nslice_of(int u);
    case (u)
      0: return 4;
      1: return 1;
      2: return 16;
      default: return 4;
    endcase
  endfunction

  function automatic logic [63:0] mask_of(int u);
    logic [63:0] m;
    m = '1;
    if (width_of(u) < 64) m = (64'd1 << width_of(u)) - 64'd1;
    return m;
  endfunction

  // Whole-word reference: the op applied to the full operand, then cut to width.
  function automatic logic [63:0] ref_op(logic [2:0] op, logic [63:0] a, logic [63:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return ~(a & b);
      3'd2: return a | b;
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic scramble(int u);
    d_a[u]  = {$urandom, $urandom};
    d_b[u]  = {$urandom, $urandom};
    d_op[u] = 3'($urandom_range(0, 7));
    d_iv[u] = 1'($urandom_range(0, 1));
  endtask

  task automatic run_txn(int u, logic [63:0] a, logic [63:0] b, logic [2:0] op, int hold, string tag);
    logic [63:0] exp;
    logic        expz;
    int          n;
    exp  = ref_op(op, a, b) & mask_of(u);
    expz = (exp == 64'd0);
    @(negedge clk);
    d_a[u] = a; d_b[u] = b; d_op[u] = op; d_iv[u] = 1'b1; d_or[u] = 1'b0;
    check($sformatf("%s in_ready_idle", tag), 64'(o_ir[u]), 64'd1);
    @(posedge clk); #1;
    scramble(u);
    n = 0;
    while (!o_ov[u] && n < nslice_of(u) + 10) begin
      @(posedge clk); #1;
      n++;
      scramble(u);
    end
    check($sformatf("%s latency", tag), 64'(n), 64'(nslice_of(u)));
    check($sformatf("%s result", tag), o_res[u], exp);
    check($sformatf("%s zero", tag), 64'(o_zero[u]), 64'(expz));
    check($sformatf("%s in_ready_done", tag), 64'(o_ir[u]), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      scramble(u);
      check($sformatf("%s hold%0d result", tag, i), o_res[u], exp);
      check($sformatf("%s hold%0d zero", tag, i), 64'(o_zero[u]), 64'(expz));
      check($sformatf("%s hold%0d out_valid", tag, i), 64'(o_ov[u]), 64'd1);
      check($sformatf("%s hold%0d in_ready", tag, i), 64'(o_ir[u]), 64'd0);
    end
    d_iv[u] = 1'b0;
    d_or[u] = 1'b1;
    @(posedge clk); #1;
    d_or[u] = 1'b0;
    check($sformatf("%s out_valid_after", tag), 64'(o_ov[u]), 64'd0);
    check($sformatf("%s in_ready_after", tag), 64'(o_ir[u]), 64'd1);
    check($sformatf("%s result_kept", tag), o_res[u], exp);
    // One idle cycle with in_valid low must not start anything.
    @(posedge clk); #1;
    check($sformatf("%s stays_idle", tag), 64'(o_ir[u]), 64'd1);
  endtask

  initial begin
    int seen_ov;
    logic [63:0] ra, rb;
    logic [2:0]  rop;
    for (int u = 0; u < 4; u++) begin
      d_a[u] = '0; d_b[u] = '0; d_op[u] = '0; d_iv[u] = 1'b0; d_or[u] = 1'b0;
    end
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      check($sformatf("rst u%0d in_ready", u), 64'(o_ir[u]), 64'd1);
      check($sformatf("rst u%0d out_valid", u), 64'(o_ov[u]), 64'd0);
      check($sformatf("rst u%0d result", u), o_res[u], 64'd0);
      check($sformatf("rst u%0d zero", u), 64'(o_zero[u]), 64'd0);
    end
    @(negedge clk); reset_n = 1'b1;

    run_txn(0, 64'hF0F0_1234, 64'hFF00_00FF, 3'd0, 5, "and32");
    run_txn(0, 64'h0000_0100, 64'h0000_0000, 3'd0, 0, "zero_and");
    run_txn(0, 64'h0000_0100, 64'h0000_0000, 3'd2, 0, "zero_or");
    run_txn(0, 64'hFFFF_FFFF, 64'h0000_0000, 3'd6, 1, "not_ones");
    run_txn(0, 64'h1234_5678, 64'h1234_5678, 3'd5, 1, "xnor_eq");

    // Reset landing mid-BUSY discards the operation.
    @(negedge clk);
    d_a[0] = 64'hDEAD_BEEF; d_b[0] = 64'h1234_5678; d_op[0] = 3'd7; d_iv[0] = 1'b1; d_or[0] = 1'b1;
    @(posedge clk); #1;
    d_iv[0] = 1'b0;
    @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst in_ready", 64'(o_ir[0]), 64'd1);
    check("midrst out_valid", 64'(o_ov[0]), 64'd0);
    check("midrst result", o_res[0], 64'd0);
    check("midrst zero", 64'(o_zero[0]), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    seen_ov = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (o_ov[0]) seen_ov++;
    end
    check("midrst no_out_valid", 64'(seen_ov), 64'd0);
    d_or[0] = 1'b0;

    for (int u = 0; u < 4; u++) begin
      for (int t = 0; t < 20; t++) begin
        ra  = {$urandom, $urandom};
        rb  = {$urandom, $urandom};
        rop = 3'($urandom_range(0, 7));
        if (t % 5 == 0) begin rb = 64'd0; rop = 3'd0; end
        if (t % 5 == 1) begin rb = ra; rop = 3'd4; end
        run_txn(u, ra, rb, rop, $urandom_range(0, 3), $sformatf("rnd u%0d t%0d", u, t));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/logic_unit_seq.md
Name: logic_unit_seq

Overview:
- Parametrised, multi-cycle bitwise logic unit for the ALU datapath; it generalises the fixed 32-bit gate arrays and the zero check.
- Operands are accepted over a valid/ready handshake and processed SLICE bits per cycle, LSB slice first.
- The unit computes one of eight bitwise ops and accumulates a zero flag across slices.
- It presents the result over a valid/ready output handshake, which lets narrow-slice builds trade latency for gate count.

Parameters:
- WIDTH, 32: operand/result width in bits. Must be a positive multiple of SLICE.
- SLICE, 8: bits processed per cycle. NSLICE = WIDTH/SLICE; the slice counter is clog2(NSLICE) bits, with a minimum of 1.

Ports:
- clk  input  1  Single clock. All state updates on the rising edge.
- reset_n  input  1  Synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  Operand/op presented.
- in_ready  output  1  Unit can accept. High only in IDLE.
- a  input  WIDTH  Operand A.
- b  input  WIDTH  Operand B.
- op  input  3  Operation select. Sampled only at accept.
- out_valid  output  1  result/zero valid. High only in DONE.
- out_ready  input  1  Consumer accepts result.
- result  output  WIDTH  Registered result.
- zero  output  1  1 when every bit of result is 0.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state goes to IDLE; in_ready=1, out_valid=0, result=0, zero=0.
  - Slice counter and the operand/op registers are cleared.
  - Reset overrides every other input on that edge, including mid-BUSY or mid-DONE. Any in-flight operation is discarded and no out_valid is produced for it.
- Op encoding:
  - 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT a (b ignored), 111 PASS a.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch a, b and op; clear the slice counter and the nonzero accumulator; go to BUSY.
  - result and zero keep their last values (not valid).
- BUSY:
  - in_ready=0. in_valid, a, b and op are ignored.
  - Each cycle with counter=k: result[k*SLICE +: SLICE] <= f(op, A[k slice], B[k slice]).
  - nonzero accumulator <= accumulator OR (reduction-OR of the computed slice).
  - Slices are written LSB first.
  - When k=NSLICE-1: zero <= ~(accumulator | slice OR), and go to DONE. Otherwise k <= k+1.
- DONE:
  - out_valid=1. result and zero are held stable.
  - On out_ready=1: go to IDLE.
  - out_ready outside DONE is ignored.
  - in_ready=0 in DONE: no same-cycle re-accept.
- Latency and throughput:
  - With the accept edge as edge 0, out_valid rises after edge NSLICE (NSLICE cycles in BUSY).
  - Minimum initiation interval is NSLICE+2 cycles when out_ready is tied high.
- Boundary cases:
  - SLICE=WIDTH: NSLICE=1, single BUSY cycle.
  - Counter wrap never occurs: the transition to DONE happens at NSLICE-1.
  - Back-pressure (out_ready=0) holds DONE indefinitely with outputs unchanged.
  - The output ports are never combinationally dependent on inputs; all are registered or decoded from state.
- Bits of result from a previous operation are fully overwritten, since all NSLICE slices are written.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles during BUSY of a WIDTH=32/SLICE=8 op -> next cycle in_ready=1, out_valid=0, result=0, zero=0. No out_valid follows without a new accept.
- AND, WIDTH=32, SLICE=8: a=F0F0_1234, b=FF00_00FF, op=000 accepted at edge 0 -> out_valid high after edge 4, result=F000_0034, zero=0.
- Zero flag across slices: a=0000_0100, b=0000_0000, op=000 -> result=0, zero=1. Same operands with op=010 -> result=0000_0100, zero=0, where only slice 1 is nonzero.
- NOT/XNOR: a=FFFF_FFFF, op=110 -> result=0, zero=1. a=b=1234_5678, op=101 -> result=FFFF_FFFF, zero=0.
- Handshake:
  - Hold out_ready=0 for 5 cycles in DONE -> result and zero stable, in_ready=0. Changing a/b/in_valid during BUSY and DONE has no effect.
  - out_ready=1 -> IDLE next cycle. The next accept needs in_valid in IDLE.
- Parameter sweep: WIDTH=8/SLICE=8, WIDTH=16/SLICE=1, WIDTH=64/SLICE=16 with random ops vs a golden bitwise model -> latency NSLICE, result and zero match on every transaction.
